// File: rtl/alu_pkg.sv
// Shared ALU function encodings, MIPS opcode/funct constants and the decoded-control record.
// Used by the ID/EX stage, its decoder and the ALU.
package alu_pkg;

  typedef enum logic [5:0] {
    AluAdd = 6'b000000,
    AluSub = 6'b000001,
    AluAnd = 6'b011000,
    AluOr  = 6'b011110,
    AluXor = 6'b010110,
    AluNor = 6'b010001,
    AluSll = 6'b100000,
    AluSrl = 6'b100001,
    AluSra = 6'b100011,
    AluEq  = 6'b110011,
    AluLt  = 6'b110101
  } alu_fun_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // Operand A source: forwarded rs, the decoded immediate (shamt for shifts), or zero (lui)
  typedef enum logic [1:0] {
    ASelRs   = 2'd0,
    ASelImm  = 2'd1,
    ASelZero = 2'd2
  } a_sel_e;

  typedef struct packed {
    logic        legal;
    alu_fun_e    alu_fun;
    logic        alu_sign;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    a_sel_e      a_sel;
    logic        b_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } dec_ctrl_t;

  localparam int unsigned DecCtrlW = $bits(dec_ctrl_t);

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decoder: turns a 32-bit MIPS word into the decoded-control record.
// Unrecognised encodings come out as an all-zero record with legal=0.
module inst_decode
  import alu_pkg::*;
(
  input  logic [31:0]         instr_i,
  output logic [DecCtrlW-1:0] ctrl_o
);

  dec_ctrl_t ctrl;

  always_comb begin
    ctrl       = '0;
    ctrl.legal = 1'b1;
    ctrl.rs    = instr_i[25:21];
    ctrl.rt    = instr_i[20:16];
    ctrl.a_sel = ASelRs;
    case (instr_i[31:26])
      OpRtype: begin
        ctrl.use_rs = 1'b1;
        ctrl.use_rt = 1'b1;
        ctrl.rd     = instr_i[15:11];
        case (instr_i[5:0])
          FnAdd:  begin ctrl.alu_fun = AluAdd; ctrl.alu_sign = 1'b1; end
          FnAddu: ctrl.alu_fun = AluAdd;
          FnSub:  begin ctrl.alu_fun = AluSub; ctrl.alu_sign = 1'b1; end
          FnSubu: ctrl.alu_fun = AluSub;
          FnAnd:  ctrl.alu_fun = AluAnd;
          FnOr:   ctrl.alu_fun = AluOr;
          FnXor:  ctrl.alu_fun = AluXor;
          FnNor:  ctrl.alu_fun = AluNor;
          FnSlt:  begin ctrl.alu_fun = AluLt; ctrl.alu_sign = 1'b1; end
          FnSltu: ctrl.alu_fun = AluLt;
          FnSll, FnSrl, FnSra: begin
            // Shifts take shamt on A and never read rs
            ctrl.use_rs = 1'b0;
            ctrl.a_sel  = ASelImm;
            ctrl.imm    = {27'b0, instr_i[10:6]};
            if (instr_i[5:0] == FnSll) begin
              ctrl.alu_fun = AluSll;
            end else if (instr_i[5:0] == FnSrl) begin
              ctrl.alu_fun = AluSrl;
            end else begin
              ctrl.alu_fun = AluSra;
            end
          end
          default: ctrl.legal = 1'b0;
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpLw: begin
        ctrl.use_rs   = 1'b1;
        ctrl.b_imm    = 1'b1;
        ctrl.imm      = {{16{instr_i[15]}}, instr_i[15:0]};
        ctrl.rd       = instr_i[20:16];
        ctrl.alu_fun  = (instr_i[31:26] == OpSlti || instr_i[31:26] == OpSltiu) ? AluLt : AluAdd;
        ctrl.alu_sign = (instr_i[31:26] == OpAddi || instr_i[31:26] == OpSlti);
        ctrl.mem_rd   = (instr_i[31:26] == OpLw);
      end
      OpAndi: begin
        ctrl.use_rs  = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.imm     = {16'b0, instr_i[15:0]};
        ctrl.rd      = instr_i[20:16];
        ctrl.alu_fun = AluAnd;
      end
      OpLui: begin
        ctrl.a_sel   = ASelZero;
        ctrl.b_imm   = 1'b1;
        ctrl.imm     = {instr_i[15:0], 16'b0};
        ctrl.rd      = instr_i[20:16];
        ctrl.alu_fun = AluAdd;
      end
      OpSw: begin
        ctrl.use_rs  = 1'b1;
        ctrl.use_rt  = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.imm     = {{16{instr_i[15]}}, instr_i[15:0]};
        ctrl.alu_fun = AluAdd;
        ctrl.mem_wr  = 1'b1;
      end
      OpBeq: begin
        ctrl.use_rs  = 1'b1;
        ctrl.use_rt  = 1'b1;
        ctrl.alu_fun = AluEq;
      end
      default: ctrl.legal = 1'b0;
    endcase
    if (!ctrl.legal) begin
      ctrl = '0;
    end
    ctrl.reg_wr = ctrl.legal & (ctrl.rd != 5'd0);
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding, load-use hazard detection and the EX register.
// Bubbles clear control outputs only; datapath registers hold their previous contents.
module id_ex_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        flush,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_addr,
  input  logic [31:0] ex_result,
  input  logic        ex_mem_read,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  output logic        stall_out,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_wr,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [31:0] ex_store_data,
  output logic        illegal
);

  logic [DecCtrlW-1:0] dec_bits;
  dec_ctrl_t           dec;

  inst_decode u_decode (
    .instr_i (id_instr),
    .ctrl_o  (dec_bits)
  );

  assign dec = dec_ctrl_t'(dec_bits);

  logic [31:0] rs_fwd, rt_fwd;
  logic        load_use, issue;

  // A load in EX has no result yet, so it is never a forwarding source
  always_comb begin
    rs_fwd = id_rs_data;
    if (dec.rs != 5'd0 && ex_wr_en && !ex_mem_read && ex_wr_addr == dec.rs) begin
      rs_fwd = ex_result;
    end else if (dec.rs != 5'd0 && mem_wr_en && mem_wr_addr == dec.rs) begin
      rs_fwd = mem_wr_data;
    end
    rt_fwd = id_rt_data;
    if (dec.rt != 5'd0 && ex_wr_en && !ex_mem_read && ex_wr_addr == dec.rt) begin
      rt_fwd = ex_result;
    end else if (dec.rt != 5'd0 && mem_wr_en && mem_wr_addr == dec.rt) begin
      rt_fwd = mem_wr_data;
    end
  end

  assign load_use  = id_valid & ex_mem_read & (ex_wr_addr != 5'd0) &
                     ((dec.use_rs & (ex_wr_addr == dec.rs)) |
                      (dec.use_rt & (ex_wr_addr == dec.rt)));
  assign stall_out = load_use & ~flush;
  assign issue     = id_valid & ~flush & ~load_use & dec.legal;

  logic [31:0] alu_a_d, alu_a_q, alu_b_d, alu_b_q, store_d, store_q;
  logic [5:0]  alu_fun_d, alu_fun_q;
  logic [4:0]  ex_rd_d, ex_rd_q;
  logic        alu_sign_d, alu_sign_q, ex_valid_d, ex_valid_q, ex_reg_wr_d, ex_reg_wr_q;
  logic        ex_mem_rd_d, ex_mem_rd_q, ex_mem_wr_d, ex_mem_wr_q, illegal_d, illegal_q;

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    alu_sign_d  = alu_sign_q;
    ex_rd_d     = ex_rd_q;
    store_d     = store_q;
    ex_valid_d  = 1'b0;
    ex_reg_wr_d = 1'b0;
    ex_mem_rd_d = 1'b0;
    ex_mem_wr_d = 1'b0;
    illegal_d   = id_valid & ~flush & ~dec.legal;
    if (issue) begin
      case (dec.a_sel)
        ASelRs:  alu_a_d = rs_fwd;
        ASelImm: alu_a_d = dec.imm;
        default: alu_a_d = 32'd0;
      endcase
      alu_b_d     = dec.b_imm ? dec.imm : rt_fwd;
      alu_fun_d   = dec.alu_fun;
      alu_sign_d  = dec.alu_sign;
      ex_rd_d     = dec.rd;
      store_d     = rt_fwd;
      ex_valid_d  = 1'b1;
      ex_reg_wr_d = dec.reg_wr;
      ex_mem_rd_d = dec.mem_rd;
      ex_mem_wr_d = dec.mem_wr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= AluAdd;
      alu_sign_q  <= 1'b0;
      ex_rd_q     <= '0;
      store_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_reg_wr_q <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_mem_wr_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_sign_q  <= alu_sign_d;
      ex_rd_q     <= ex_rd_d;
      store_q     <= store_d;
      ex_valid_q  <= ex_valid_d;
      ex_reg_wr_q <= ex_reg_wr_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_mem_wr_q <= ex_mem_wr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_fun       = alu_fun_q;
  assign alu_sign      = alu_sign_q;
  assign ex_rd         = ex_rd_q;
  assign ex_store_data = store_q;
  assign ex_valid      = ex_valid_q;
  assign ex_reg_wr     = ex_reg_wr_q;
  assign ex_mem_rd     = ex_mem_rd_q;
  assign ex_mem_wr     = ex_mem_wr_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 id_valid, id_instr[31:0], id_rs_data[31:0], id_rt_data[31:0]  in  decode-stage instruction and register-file read data.
REQ-004 flush  in  1  branch/jump redirect; kills the instruction entering EX.
REQ-005 ex_wr_en, ex_wr_addr[4:0], ex_result[31:0], ex_mem_read  in  writeback info of the instruction currently in EX.
REQ-006 mem_wr_en, mem_wr_addr[4:0], mem_wr_data[31:0]  in  writeback info of the instruction in MEM.
REQ-007 stall_out  out  1  combinational; upstream holds PC/IF/ID while high.
REQ-008 alu_a[31:0], alu_b[31:0], alu_fun[5:0], alu_sign  out  registered operands/control for the ALU.
REQ-009 ex_valid, ex_rd[4:0], ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_store_data[31:0], illegal  out  registered EX-stage control.

Function
REQ-010 Latency SHALL be one cycle: decoded, forwarded values appear on outputs the edge after id_valid is sampled.
REQ-011 alu_fun SHALL use the shared encoding: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, LT 110101.
REQ-012 Decode set: add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra (R-type); addi/addiu/andi/slti/sltiu/lui/lw/sw/beq; alu_sign=1 for add/sub/addi/slt/slti, else 0.
REQ-013 Immediates: sign-extend for addi/addiu/slti/sltiu/lw/sw/beq; zero-extend for andi; lui drives alu_a=0, alu_b={imm,16'b0}, alu_fun=ADD.
REQ-014 Shifts SHALL drive alu_a={27'b0,shamt}, alu_b=forwarded rt value.
REQ-015 Destination: rd for R-type, rt for I-type loads/ALU-imm/lui; ex_reg_wr=0 for sw/beq and whenever destination is register 0.
REQ-016 Forwarding per source operand: ex match (ex_wr_en, addr!=0, addr==src, !ex_mem_read) beats mem match (mem_wr_en, addr!=0) beats register-file data; register 0 never forwarded.
REQ-017 ex_store_data SHALL be the forwarded rt value.
REQ-018 Load-use hazard: stall_out=1 when id_valid & ex_mem_read & ex_wr_addr!=0 & ex_wr_addr equals a source register actually read by the instruction.
REQ-019 While stall_out=1 the next registered state SHALL be a bubble (ex_valid=0, ex_reg_wr=0, ex_mem_rd=0, ex_mem_wr=0); stall lasts exactly one cycle per hazard.
REQ-020 flush SHALL override stall and id_valid: next state is a bubble, stall_out forced 0.
REQ-021 id_valid=0 SHALL load a bubble; datapath outputs may hold, control outputs SHALL be 0.
REQ-022 Unrecognised opcode/funct with id_valid=1: bubble plus illegal=1 for one cycle.

Reset
REQ-023 On reset=0 all registered outputs SHALL be 0 (alu_fun=ADD, ex_valid=0, illegal=0) asynchronously.
REQ-024 Reset mid-stall SHALL drop the pending bubble; first post-reset cycle behaves as an empty pipeline.

Structure
REQ-025 alu_fun encodings, opcode/funct constants and the decoded-control record SHALL live in shared package alu_pkg used also by the ALU.
REQ-026 Decode SHALL be a combinational sub-module inst_decode; forwarding, hazard and pipeline register stay in id_ex_stage.
REQ-027 Implementation SHALL be 120-400 RTL lines, no latches, single always block for the pipeline register.

Verification
REQ-028 add $3,$1,$2 with rs=5, rt=7, no forwarding -> next cycle alu_a=5, alu_b=7, alu_fun=000000, alu_sign=1, ex_rd=3, ex_reg_wr=1.
REQ-029 ex_wr_addr=1, ex_result=0x10, mem_wr_addr=1, mem_wr_data=0x20, decode sub $4,$1,$1 -> alu_a=alu_b=0x10, alu_fun=000001.
REQ-030 ex_mem_read=1, ex_wr_addr=2, decode addi $5,$2,-1 -> stall_out=1 one cycle, bubble out; next cycle alu_b=0xFFFFFFFF.
REQ-031 flush=1 with load-use hazard present -> stall_out=0, ex_valid=0 next cycle.
REQ-032 lui $6,0x1234 -> alu_a=0, alu_b=0x12340000; sll $7,$8,3 -> alu_a=3, alu_fun=100000; reset=0 mid-stream -> all outputs 0 immediately.
